// File: rtl/ysyx_24090012_lsu_pkg.sv
`default_nettype none
// ysyx_24090012_lsu_pkg -- shared opcodes, funct3 codes and FSM state type. Rev 1.0
package ysyx_24090012_lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_opcode(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24090012_lsu_if.sv
`default_nettype none
// ysyx_24090012_lsu_if -- EXU request port plus data-memory bus, master = LSU side. Rev 1.0
interface ysyx_24090012_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [31:0]       exu_to_lsu_inst;
  logic              mem_ready;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_is_load;
  logic              lsu_misalign;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wen;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_wmask;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_rdata;

  modport master (
    input  mem_valid, mem_addr, mem_wdata, exu_to_lsu_inst,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata,
    output mem_ready, lsu_rdata, lsu_is_load, lsu_misalign,
    output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask
  );

  modport slave (
    output mem_valid, mem_addr, mem_wdata, exu_to_lsu_inst,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata,
    input  mem_ready, lsu_rdata, lsu_is_load, lsu_misalign,
    input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_24090012_lsu_align.sv
`default_nettype none
// ysyx_24090012_lsu_align -- byte-lane mask/shift for stores, shift/extend for loads, alignment flag.
// Rev 1.0
module ysyx_24090012_lsu_align
  import ysyx_24090012_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] rsh;
  logic [31:0] wsh;

  always_comb begin
    rsh       = rword >> {off, 3'b000};
    wsh       = wdata << {off, 3'b000};
    wmask     = 4'b1111;
    wdata_sh  = wdata;
    rdata_ext = rword;
    misalign  = 1'b0;
    // funct3[2] distinguishes the zero-extending BU/HU from signed B/H
    case (funct3)
      F3_B, F3_BU: begin
        wmask     = 4'b0001 << off;
        wdata_sh  = wsh;
        rdata_ext = {{24{rsh[7] & ~funct3[2]}}, rsh[7:0]};
      end
      F3_H, F3_HU: begin
        wmask     = 4'b0011 << off;
        wdata_sh  = wsh;
        rdata_ext = {{16{rsh[15] & ~funct3[2]}}, rsh[15:0]};
        misalign  = off[0];
      end
      F3_W: begin
        misalign  = (off != 2'b00);
      end
      default: begin
        misalign  = (off != 2'b00);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24090012_lsu.sv
`default_nettype none
// ysyx_24090012_lsu -- LSU top: request FSM and capture registers. Rev 1.0
// Optional macro YSYX_24090012_LSU_ALIGN_CHECK_EN: misaligned H/W accesses complete without bus traffic.
module ysyx_24090012_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_24090012_lsu_if.master io
);

  import ysyx_24090012_lsu_pkg::*;

  lsu_state_e        state_q, state_d;
  logic              mem_ready_q, mem_ready_d;
  logic              is_load_q, is_load_d;
  logic              misalign_q, misalign_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_req_valid_q, bus_req_valid_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_wen_q, bus_wen_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_wmask_q, bus_wmask_d;

  logic [6:0]  in_opcode;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_idle;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;
  logic        trap;

  assign in_opcode   = io.exu_to_lsu_inst[6:0];
  assign in_is_load  = (in_opcode == OPC_LOAD);
  assign in_is_store = (in_opcode == OPC_STORE);
  assign in_idle     = (state_q == IDLE);

  // Live EXU fields feed the aligner while accepting; captured ones afterwards.
  assign al_funct3 = in_idle ? io.exu_to_lsu_inst[14:12] : funct3_q;
  assign al_off    = in_idle ? io.mem_addr[1:0] : off_q;

  ysyx_24090012_lsu_align u_align (
    .funct3    (al_funct3),
    .off       (al_off),
    .wdata     (io.mem_wdata),
    .rword     (io.bus_resp_rdata),
    .wmask     (al_wmask),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

`ifdef YSYX_24090012_LSU_ALIGN_CHECK_EN
  assign trap = al_misalign;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    mem_ready_d     = 1'b0;
    is_load_d       = is_load_q;
    misalign_d      = misalign_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    rdata_d         = rdata_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_addr_d      = bus_addr_q;
    bus_wen_d       = bus_wen_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wmask_d     = bus_wmask_q;

    case (state_q)
      IDLE: begin
        if (io.mem_valid) begin
          is_load_d  = in_is_load;
          misalign_d = 1'b0;
          funct3_d   = io.exu_to_lsu_inst[14:12];
          off_d      = io.mem_addr[1:0];
          rdata_d    = '0;
          if (is_mem_opcode(in_opcode) && !trap) begin
            state_d         = REQ;
            bus_req_valid_d = 1'b1;
            bus_addr_d      = {io.mem_addr[ADDR_W-1:2], 2'b00};
            bus_wen_d       = in_is_store;
            bus_wdata_d     = in_is_store ? al_wdata : '0;
            bus_wmask_d     = in_is_store ? al_wmask : 4'b0000;
          end else begin
            state_d     = ACK;
            mem_ready_d = 1'b1;
            misalign_d  = trap;
          end
        end
      end
      REQ: begin
        if (io.bus_req_ready) begin
          bus_req_valid_d = 1'b0;
          if (io.bus_resp_valid) begin
            state_d     = ACK;
            mem_ready_d = 1'b1;
            rdata_d     = is_load_q ? al_rdata : '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (io.bus_resp_valid) begin
          state_d     = ACK;
          mem_ready_d = 1'b1;
          rdata_d     = is_load_q ? al_rdata : '0;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      mem_ready_q     <= 1'b0;
      is_load_q       <= 1'b0;
      misalign_q      <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      rdata_q         <= '0;
      bus_req_valid_q <= 1'b0;
      bus_addr_q      <= '0;
      bus_wen_q       <= 1'b0;
      bus_wdata_q     <= '0;
      bus_wmask_q     <= 4'b0000;
    end else begin
      state_q         <= state_d;
      mem_ready_q     <= mem_ready_d;
      is_load_q       <= is_load_d;
      misalign_q      <= misalign_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      rdata_q         <= rdata_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_addr_q      <= bus_addr_d;
      bus_wen_q       <= bus_wen_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wmask_q     <= bus_wmask_d;
    end
  end

  assign io.mem_ready     = mem_ready_q;
  assign io.lsu_rdata     = rdata_q;
  assign io.lsu_is_load   = is_load_q;
  assign io.bus_req_valid = bus_req_valid_q;
  assign io.bus_addr      = bus_addr_q;
  assign io.bus_wen       = bus_wen_q;
  assign io.bus_wdata     = bus_wdata_q;
  assign io.bus_wmask     = bus_wmask_q;

  logic unused_ok;
`ifdef YSYX_24090012_LSU_ALIGN_CHECK_EN
  assign io.lsu_misalign = misalign_q;
  assign unused_ok = ^{io.exu_to_lsu_inst[31:15], io.exu_to_lsu_inst[11:7]};
`else
  assign io.lsu_misalign = 1'b0;
  assign unused_ok = ^{io.exu_to_lsu_inst[31:15], io.exu_to_lsu_inst[11:7],
                       al_misalign, misalign_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090012_lsu.sv
`default_nettype none
// tb_ysyx_24090012_lsu -- directed and randomized checks of the LSU against a behavioural model.
// Rev 1.0
module tb_ysyx_24090012_lsu;

`ifdef YSYX_24090012_LSU_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24090012_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  ysyx_24090012_lsu #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          lat;
    int          nreq;
    bit          unstable;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        is_load;
    logic        misalign;
    logic        ready_after;
  } obs_t;

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    return {12'h004, 5'd3, f3, 5'd5, opc};
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int o = int'(addr % 4);
    return (size_of(f3) == 2 && (o % 2) == 1) || (size_of(f3) == 4 && o != 0);
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    longint m;
    if (sz == 4) return 4'hF;
    m = ((64'd1 << sz) - 1) << (addr % 4);
    return 4'(m % 16);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] wd);
    longint v;
    if (size_of(f3) == 4) return wd;
    v = {32'd0, wd} * (64'd1 << (8 * (addr % 4)));
    return 32'(v % (64'd1 << 32));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rword);
    int     sz = size_of(f3);
    longint v, lim;
    if (sz == 4) return rword;
    v   = {32'd0, rword} / (64'd1 << (8 * (addr % 4)));
    lim = 64'd1 << (8 * sz);
    v   = v % lim;
    if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // ---------------- EXU + memory driver ----------------
  task automatic run_req(input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword,
                         input int stall, input int wt, input bit scramble,
                         output obs_t o);
    int nreq = 0;
    int wc   = 0;
    bit acc  = 0;
    o = '{default: '0};
    @(negedge clk);
    bus_if.mem_valid       = 1'b1;
    bus_if.mem_addr        = addr;
    bus_if.mem_wdata       = wdata;
    bus_if.exu_to_lsu_inst = inst;
    bus_if.bus_req_ready   = 1'b0;
    bus_if.bus_resp_valid  = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (scramble) begin
        bus_if.mem_addr        = $urandom;
        bus_if.mem_wdata       = $urandom;
        bus_if.exu_to_lsu_inst = $urandom;
      end
      bus_if.bus_resp_rdata = $urandom;
      if (bus_if.mem_ready === 1'b1) begin
        o.lat      = k;
        o.rdata    = bus_if.lsu_rdata;
        o.is_load  = bus_if.lsu_is_load;
        o.misalign = bus_if.lsu_misalign;
        break;
      end
      if (bus_if.bus_req_valid === 1'b1) begin
        nreq++;
        if (nreq == 1) begin
          o.addr  = bus_if.bus_addr;
          o.wen   = bus_if.bus_wen;
          o.wdata = bus_if.bus_wdata;
          o.mask  = bus_if.bus_wmask;
        end else if ({o.addr, o.wen, o.wdata, o.mask} !==
                     {bus_if.bus_addr, bus_if.bus_wen, bus_if.bus_wdata, bus_if.bus_wmask}) begin
          o.unstable = 1'b1;
        end
        if (nreq > stall) begin
          bus_if.bus_req_ready  = 1'b1;
          bus_if.bus_resp_valid = (wt == 0);
          acc = 1'b1;
          if (wt == 0) bus_if.bus_resp_rdata = rword;
        end else begin
          bus_if.bus_req_ready  = 1'b0;
          bus_if.bus_resp_valid = 1'b0;
        end
      end else if (acc) begin
        wc++;
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = (wc == wt);
        if (wc == wt) bus_if.bus_resp_rdata = rword;
      end else begin
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
      end
    end
    o.nreq = nreq;
    bus_if.mem_valid      = 1'b0;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    @(negedge clk);
    o.ready_after = bus_if.mem_ready;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_if.mem_valid = 1'b0; bus_if.mem_addr = '0; bus_if.mem_wdata = '0;
    bus_if.exu_to_lsu_inst = '0; bus_if.bus_req_ready = 1'b0;
    bus_if.bus_resp_valid = 1'b0; bus_if.bus_resp_rdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_ready, bus_if.lsu_rdata, bus_if.lsu_is_load, bus_if.lsu_misalign} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_exu_outputs: got ready=%b rdata=%h ld=%b mis=%b want all 0",
               bus_if.mem_ready, bus_if.lsu_rdata, bus_if.lsu_is_load, bus_if.lsu_misalign);
    end
    n_cmp++;
    if ({bus_if.bus_req_valid, bus_if.bus_addr, bus_if.bus_wen, bus_if.bus_wdata, bus_if.bus_wmask} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_bus_outputs: got v=%b a=%h w=%b d=%h m=%b want all 0", bus_if.bus_req_valid,
               bus_if.bus_addr, bus_if.bus_wen, bus_if.bus_wdata, bus_if.bus_wmask);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    obs_t o;
    run_req(mk_inst(OP_LOAD, 3'b010), 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, o);
    n_cmp++; if (o.lat !== 2) begin n_err++; $display("FAIL lw_latency: got %0d want 2", o.lat); end
    n_cmp++; if (o.addr !== 32'h8000_0010) begin n_err++; $display("FAIL lw_bus_addr: got %h want 80000010", o.addr); end
    n_cmp++; if (o.wen !== 1'b0) begin n_err++; $display("FAIL lw_wen: got %b want 0", o.wen); end
    n_cmp++; if (o.rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_rdata: got %h want deadbeef", o.rdata); end
    n_cmp++; if (o.is_load !== 1'b1) begin n_err++; $display("FAIL lw_is_load: got %b want 1", o.is_load); end
    n_cmp++; if (o.ready_after !== 1'b0) begin n_err++; $display("FAIL lw_ready_pulse: got %b want 0", o.ready_after); end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    run_req(mk_inst(OP_LOAD, 3'b000), 32'h8000_0013, 32'h0, 32'h80FF_0000, 0, 1, 1'b0, o);
    n_cmp++; if (o.rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %h want ffffff80", o.rdata); end
    n_cmp++; if (o.lat !== 3) begin n_err++; $display("FAIL lb_latency: got %0d want 3", o.lat); end
    n_cmp++; if (o.addr !== 32'h8000_0010) begin n_err++; $display("FAIL lb_bus_addr: got %h want 80000010", o.addr); end
    run_req(mk_inst(OP_LOAD, 3'b100), 32'h8000_0013, 32'h0, 32'h80FF_0000, 0, 0, 1'b0, o);
    n_cmp++; if (o.rdata !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_rdata: got %h want 00000080", o.rdata); end
  endtask

  task automatic test_sh_stall();
    obs_t o;
    run_req(mk_inst(OP_STORE, 3'b001), 32'h8000_0002, 32'h0000_1234, 32'hFFFF_FFFF, 3, 0, 1'b0, o);
    n_cmp++; if (o.lat !== 5) begin n_err++; $display("FAIL sh_latency: got %0d want 5", o.lat); end
    n_cmp++; if (o.mask !== 4'b1100) begin n_err++; $display("FAIL sh_wmask: got %b want 1100", o.mask); end
    n_cmp++; if (o.wdata !== 32'h1234_0000) begin n_err++; $display("FAIL sh_wdata: got %h want 12340000", o.wdata); end
    n_cmp++; if (o.wen !== 1'b1) begin n_err++; $display("FAIL sh_wen: got %b want 1", o.wen); end
    n_cmp++; if (o.unstable !== 1'b0) begin n_err++; $display("FAIL sh_req_stable: fields changed during stall"); end
    n_cmp++; if ({o.rdata, o.is_load} !== 33'd0) begin n_err++; $display("FAIL sh_rdata: got %h/%b want 0/0", o.rdata, o.is_load); end
  endtask

  task automatic test_nonmem();
    obs_t o;
    run_req(mk_inst(OP_ADDI, 3'b000), 32'h8000_0004, 32'h5555_AAAA, 32'h1111_1111, 0, 0, 1'b0, o);
    n_cmp++; if (o.lat !== 1) begin n_err++; $display("FAIL addi_latency: got %0d want 1", o.lat); end
    n_cmp++; if (o.nreq !== 0) begin n_err++; $display("FAIL addi_no_bus: got %0d requests want 0", o.nreq); end
    n_cmp++; if ({o.rdata, o.is_load} !== 33'd0) begin n_err++; $display("FAIL addi_rdata: got %h/%b want 0/0", o.rdata, o.is_load); end
  endtask

  task automatic test_misalign();
    obs_t o;
    int exp_lat = CHECK_EN ? 1 : 2;
    int exp_nreq = CHECK_EN ? 0 : 1;
    logic [31:0] exp_rd = CHECK_EN ? 32'h0 : 32'hCAFE_F00D;
    run_req(mk_inst(OP_LOAD, 3'b010), 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, o);
    n_cmp++; if (o.lat !== exp_lat) begin n_err++; $display("FAIL mis_latency: got %0d want %0d", o.lat, exp_lat); end
    n_cmp++; if (o.nreq !== exp_nreq) begin n_err++; $display("FAIL mis_bus_reqs: got %0d want %0d", o.nreq, exp_nreq); end
    n_cmp++; if (o.misalign !== CHECK_EN) begin n_err++; $display("FAIL mis_flag: got %b want %b", o.misalign, CHECK_EN); end
    n_cmp++; if (o.rdata !== exp_rd) begin n_err++; $display("FAIL mis_rdata: got %h want %h", o.rdata, exp_rd); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [31:0] rw;
    // reset while the request is on the bus
    @(negedge clk);
    bus_if.mem_valid = 1'b1; bus_if.mem_addr = 32'h8000_0040;
    bus_if.exu_to_lsu_inst = mk_inst(OP_LOAD, 3'b010);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req_valid !== 1'b1) begin n_err++; $display("FAIL rstreq_pre: got %b want 1", bus_if.bus_req_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus_if.bus_req_valid, bus_if.mem_ready} !== 2'b00) begin
      n_err++; $display("FAIL rstreq_drop: got v=%b r=%b want 0 0", bus_if.bus_req_valid, bus_if.mem_ready); end
    bus_if.mem_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    // reset while waiting for the response
    @(negedge clk);
    bus_if.mem_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); bus_if.bus_req_ready = 1'b1; bus_if.bus_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); bus_if.bus_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus_if.bus_req_valid, bus_if.mem_ready, bus_if.lsu_rdata} !== 34'd0) begin
      n_err++; $display("FAIL rstwait_outputs: got v=%b r=%b d=%h want 0 0 0",
                        bus_if.bus_req_valid, bus_if.mem_ready, bus_if.lsu_rdata); end
    bus_if.mem_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus_if.bus_resp_valid = 1'b1; bus_if.bus_resp_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus_if.mem_ready, bus_if.bus_req_valid} !== 2'b00) begin
        n_err++; $display("FAIL stale_resp_%0d: got r=%b v=%b want 0 0", i, bus_if.mem_ready, bus_if.bus_req_valid); end
    end
    bus_if.bus_resp_valid = 1'b0;
    rw = $urandom;
    run_req(mk_inst(OP_LOAD, 3'b010), 32'h8000_0020, 32'h0, rw, 0, 0, 1'b0, o);
    n_cmp++; if (o.lat !== 2) begin n_err++; $display("FAIL post_rst_latency: got %0d want 2", o.lat); end
    n_cmp++; if (o.rdata !== rw) begin n_err++; $display("FAIL post_rst_rdata: got %h want %h", o.rdata, rw); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      int          kind  = $urandom_range(0, 2);
      logic [31:0] addr  = $urandom;
      logic [31:0] wd    = $urandom;
      logic [31:0] rw    = $urandom;
      int          stall = $urandom_range(0, 3);
      int          wt    = $urandom_range(0, 3);
      logic [2:0]  f3;
      logic [6:0]  opc;
      bit          is_ld, is_st, trapped;
      int          exp_lat;
      logic [31:0] exp_rd;
      if (kind == 0) begin
        opc = OP_LOAD;  f3 = 3'($urandom_range(0, 7));
      end else if (kind == 1) begin
        opc = OP_STORE; f3 = 3'($urandom_range(0, 2));
      end else begin
        f3 = 3'($urandom_range(0, 7));
        do opc = 7'($urandom); while (opc == OP_LOAD || opc == OP_STORE);
      end
      is_ld   = (kind == 0);
      is_st   = (kind == 1);
      trapped = CHECK_EN && (is_ld || is_st) && ref_misaligned(f3, addr);
      exp_lat = (!(is_ld || is_st) || trapped) ? 1 : 2 + stall + wt;
      exp_rd  = (is_ld && !trapped) ? ref_load(f3, addr, rw) : 32'h0;
      run_req({$urandom_range(0, 131071), f3, 5'($urandom), opc}, addr, wd, rw, stall, wt, 1'b1, o);
      n_cmp++; if (o.lat !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.lat, exp_lat); end
      n_cmp++; if (o.rdata !== exp_rd) begin n_err++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o.rdata, exp_rd); end
      n_cmp++; if (o.is_load !== is_ld) begin n_err++; $display("FAIL rnd%0d_is_load: got %b want %b", i, o.is_load, is_ld); end
      n_cmp++; if (o.misalign !== trapped) begin n_err++; $display("FAIL rnd%0d_misalign: got %b want %b", i, o.misalign, trapped); end
      n_cmp++; if (o.ready_after !== 1'b0) begin n_err++; $display("FAIL rnd%0d_ready_pulse: got %b want 0", i, o.ready_after); end
      if ((is_ld || is_st) && !trapped) begin
        n_cmp++; if (o.nreq !== stall + 1) begin n_err++; $display("FAIL rnd%0d_req_cycles: got %0d want %0d", i, o.nreq, stall + 1); end
        n_cmp++; if (o.addr !== {addr[31:2], 2'b00}) begin n_err++; $display("FAIL rnd%0d_bus_addr: got %h want %h", i, o.addr, {addr[31:2], 2'b00}); end
        n_cmp++; if (o.wen !== is_st) begin n_err++; $display("FAIL rnd%0d_wen: got %b want %b", i, o.wen, is_st); end
        n_cmp++; if (o.unstable !== 1'b0) begin n_err++; $display("FAIL rnd%0d_req_stable: fields changed in request", i); end
      end else begin
        n_cmp++; if (o.nreq !== 0) begin n_err++; $display("FAIL rnd%0d_no_bus: got %0d requests want 0", i, o.nreq); end
      end
      if (is_st && !trapped) begin
        n_cmp++; if (o.mask !== ref_mask(f3, addr)) begin n_err++; $display("FAIL rnd%0d_wmask: got %b want %b", i, o.mask, ref_mask(f3, addr)); end
        n_cmp++; if (o.wdata !== ref_wdata(f3, addr, wd)) begin n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o.wdata, ref_wdata(f3, addr, wd)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_stall();
    test_nonmem();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
